alu_exec_md: RTL and testbench

- Execute-stage datapath block that consumes the 3-bit ALU control code and the decoded register operands.
- Combinational 32-bit integer ALU: result, zero and overflow flags.
- Iterative multi-cycle multiply/divide unit that owns the HI/LO registers and raises a stall while it is busy.
- Sits between the ALU-control decoder/register file and the writeback mux of the MIPS core.

---
 rtl/alu_exec_md_if.sv | 27 ++
 rtl/alu_exec_md.sv | 157 +++++++++++++++
 tb/tb_alu_exec_md.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_md_if.sv
// Execute-stage bus: ALU operands/result plus the mul/div request and HI/LO view.
interface alu_exec_md_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             md_start;
  logic [1:0]       md_op;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output alu_ctrl, a, b, md_start, md_op,
    input  result, zero, ovf, md_busy, md_done, hi, lo
  );

  modport slave (
    input  alu_ctrl, a, b, md_start, md_op,
    output result, zero, ovf, md_busy, md_done, hi, lo
  );
endinterface

// File: rtl/alu_exec_md.sv
// MIPS execute stage: combinational 32-bit ALU plus an iterative mul/div unit owning HI/LO.
module alu_exec_md #(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_exec_md_if.slave  bus
);
  localparam int CW = $clog2(MD_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  // ---------------- ALU ----------------
  logic [WIDTH-1:0] sum, dif, alu_res;
  logic             alu_ovf;

  assign sum = bus.a + bus.b;
  assign dif = bus.a - bus.b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.alu_ctrl)
      3'b000: alu_res = bus.a & bus.b;
      3'b001: alu_res = bus.a | bus.b;
      3'b010: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b011: alu_res = sum;
      3'b110: begin
        alu_res = dif;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

  assign bus.result = alu_res;
  assign bus.zero   = (alu_res == '0);
  assign bus.ovf    = alu_ovf;

  // ---------------- mul/div ----------------
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}; divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [1:0]         op_q, op_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               sgn_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     msum, shl, dtry;
  logic [2*WIDTH-1:0] mul_step, div_step;

  assign sgn_op = bus.md_op[0];
  assign a_mag  = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag  = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign msum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {msum, prod_q[WIDTH-1:1]};

  assign shl      = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign dtry     = shl - {1'b0, opnd_q};
  assign div_step = dtry[WIDTH] ? {shl[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                : {dtry[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: if (bus.md_start) begin
        state_d = S_RUN;
        cnt_d   = '0;
        op_d    = bus.md_op;
        araw_d  = bus.a;
        neg_a_d = sgn_op & bus.a[WIDTH-1];
        neg_b_d = sgn_op & bus.b[WIDTH-1];
        opnd_d  = bus.md_op[1] ? b_mag : a_mag;
        prod_d  = {{WIDTH{1'b0}}, (bus.md_op[1] ? a_mag : b_mag)};
        busy_d  = 1'b1;
      end
      S_RUN: begin
        prod_d = op_q[1] ? div_step : mul_step;
        if (cnt_q == CW'(MD_CYCLES-1)) state_d = S_FIN;
        else                           cnt_d   = cnt_q + CW'(1);
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
        end else if (opnd_q == '0) begin
          // Divide by zero is not trapped: return all-ones quotient, raw dividend.
          lo_d = '1;
          hi_d = araw_q;
        end else begin
          lo_d = (neg_a_q ^ neg_b_q) ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
          hi_d = neg_a_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opnd_q  <= '0;
      araw_q  <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.md_busy = busy_q;
  assign bus.md_done = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule

// File: tb/tb_alu_exec_md.sv
// Directed bench for alu_exec_md: behavioural model compared every cycle plus literal checks.
module tb_alu_exec_md;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_exec_md_if #(.WIDTH(32)) bus ();
  alu_exec_md #(.WIDTH(32), .MD_CYCLES(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ALU model in plain integer arithmetic: {ovf, zero, result}.
  function automatic logic [33:0] alu_model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, s, lim_hi, lim_lo;
    logic [31:0] r;
    logic o;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lim_hi = (longint'(1) <<< 31) - 1;
    lim_lo = -(longint'(1) <<< 31);
    r = 32'h0;
    o = 1'b0;
    s = 0;
    case (c)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin s = sx + sy; r = s[31:0]; o = (s > lim_hi) || (s < lim_lo); end
      3'b011: r = x + y;
      3'b110: begin s = sx - sy; r = s[31:0]; o = (s > lim_hi) || (s < lim_lo); end
      3'b111: r = (sx < sy) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
    return {o, (r == 32'h0), r};
  endfunction

  // Mul/div model: {HI, LO}.
  function automatic logic [63:0] md_model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ux, uy;
    longint p;
    int q, r;
    case (op)
      2'b00: begin ux = {32'h0, x}; uy = {32'h0, y}; return ux * uy; end
      2'b01: begin p = longint'($signed(x)) * longint'($signed(y)); return p; end
      2'b10: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
    endcase
  endfunction

  // Timing model: busy for MD_CYCLES+1 cycles after accept, then one done cycle with new HI/LO.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
  logic [63:0] m_pend = 64'h0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_hi <= 32'h0; m_lo <= 32'h0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0];
        end
        m_left <= m_left - 1;
      end else if (bus.md_start) begin
        m_pend <= md_model(bus.md_op, bus.a, bus.b);
        m_busy <= 1'b1;
        m_left <= 33;
      end
    end
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (chk_en) begin
      e = alu_model(bus.alu_ctrl, bus.a, bus.b);
      chk("cyc_result", 64'(bus.result), 64'(e[31:0]));
      chk("cyc_zero", 64'(bus.zero), 64'(e[32]));
      chk("cyc_ovf", 64'(bus.ovf), 64'(e[33]));
      chk("cyc_busy", 64'(bus.md_busy), 64'(m_busy));
      chk("cyc_done", 64'(bus.md_done), 64'(m_done));
      chk("cyc_hi", 64'(bus.hi), 64'(m_hi));
      chk("cyc_lo", 64'(bus.lo), 64'(m_lo));
    end
  end

  // All tasks start and end right at a negedge; inputs change 1 time unit later.
  task automatic alu_chk(input string nm, input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic ez, input logic eo);
    #1 bus.alu_ctrl = c; bus.a = x; bus.b = y;
    @(negedge clk);
    chk({nm, "_res"}, 64'(bus.result), 64'(er));
    chk({nm, "_zero"}, 64'(bus.zero), 64'(ez));
    chk({nm, "_ovf"}, 64'(bus.ovf), 64'(eo));
  endtask

  task automatic run_md(input string nm, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int busy_n, done_k;
    #1 bus.md_op = op; bus.a = x; bus.b = y; bus.md_start = 1'b1;
    @(posedge clk);
    #2 bus.md_start = 1'b0;
    busy_n = 0;
    done_k = 0;
    for (int k = 1; k <= 60 && done_k == 0; k++) begin
      @(negedge clk);
      if (bus.md_busy) busy_n++;
      if (bus.md_done) done_k = k;
    end
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'd33);
    chk({nm, "_done_edge"}, 64'(done_k), 64'd34);
    chk({nm, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({nm, "_lo"}, 64'(bus.lo), 64'(elo));
  endtask

  initial begin
    int ndone;
    bus.alu_ctrl = 3'b000; bus.a = 32'h0; bus.b = 32'h0; bus.md_start = 1'b0; bus.md_op = 2'b00;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(bus.md_busy), 64'h0);
    chk("rst_done", 64'(bus.md_done), 64'h0);
    chk("rst_hi", 64'(bus.hi), 64'h0);
    chk("rst_lo", 64'(bus.lo), 64'h0);
    #1 rst = 1'b0;
    @(negedge clk);

    alu_chk("add_ovf", 3'b010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1);
    alu_chk("sub_zero", 3'b110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    alu_chk("slt", 3'b111, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0);
    alu_chk("and", 3'b000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0);
    alu_chk("code100", 3'b100, 32'h12345678, 32'h9, 32'h0, 1'b1, 1'b0);
    alu_chk("code101", 3'b101, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0);
    alu_chk("addu_noovf", 3'b011, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0);
    alu_chk("sub_ovf", 3'b110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1);
    alu_chk("or", 3'b001, 32'hA0000005, 32'h0000000A, 32'hA000000F, 1'b0, 1'b0);
    alu_chk("slt_false", 3'b111, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);

    run_md("mult", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("multu", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_md("div", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu0", 2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    run_md("div_min", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_md("div0_s", 2'b11, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);

    // Starts while busy must be ignored.
    #1 bus.md_op = 2'b00; bus.a = 32'd2; bus.b = 32'd3; bus.md_start = 1'b1;
    @(posedge clk);
    #2 bus.md_start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (bus.md_done) ndone++;
      if (k == 5 || k == 10) begin
        #1 bus.md_op = 2'b01; bus.a = 32'd7; bus.b = 32'd9; bus.md_start = 1'b1;
        @(posedge clk);
        #2 bus.md_start = 1'b0;
      end
    end
    chk("ignore_ndone", 64'(ndone), 64'd1);
    chk("ignore_lo", 64'(bus.lo), 64'd6);
    chk("ignore_hi", 64'(bus.hi), 64'd0);

    // Back-to-back: second start lands on the done cycle.
    run_md("b2b_first", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30);
    run_md("b2b_second", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);

    // Reset mid-divide aborts without a write.
    #1 bus.md_op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3; bus.md_start = 1'b1;
    @(posedge clk);
    #2 bus.md_start = 1'b0;
    repeat (15) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(bus.md_busy), 64'h0);
    chk("abort_hi", 64'(bus.hi), 64'h0);
    chk("abort_lo", 64'(bus.lo), 64'h0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.md_done) ndone++;
    end
    chk("abort_nodone", 64'(ndone), 64'd0);
    run_md("after_rst", 2'b00, 32'd4, 32'd4, 32'd0, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
